// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Package project_types: stall vector, PC, reset polarity and controller state.
package project_types;

  typedef logic [5:0]  stall_t;
  typedef logic [31:0] pc_t;
  typedef logic        reset_status_t;

  localparam reset_status_t RST_ENABLE = 1'b0;

  // Stall patterns: each deeper request also freezes every earlier stage.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// pipe_watchdog: counts consecutive cycles with the PC stalled and raises a
// sticky timeout once WDOG_LIMIT is reached. Only built with PIPE_WATCHDOG_EN.
module pipe_watchdog
  import project_types::*;
#(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          stall_pc,
  input  logic          in_flush,
  output logic          timeout
);

  localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WDOG_LIMIT - 1);

  logic [CW-1:0] cnt;

  // Consecutive-stall counter; once tripped, the flag and the counter freeze until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (!timeout) begin
      if (!stall_pc || in_flush) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stage stall requests, sequences exception flushes
// with a redirect PC and counts stalled cycles.
// Optional feature macro: PIPE_WATCHDOG_EN adds a consecutive-stall watchdog.
module pipeline_ctrl
  import project_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic             clk,
  input  reset_status_t    rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  pc_t              excp_vector,
  input  logic             perf_clr,
  output stall_t           stall,
  output logic             flush,
  output pc_t              new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wdog_timeout
);

  // Reject out-of-range configurations at elaboration.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pipeline_ctrl: FLUSH_CYCLES must be 1..7");
  end
  if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
    $error("pipeline_ctrl: WDOG_LIMIT must be at least 1");
  end

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  pipe_ctrl_state_t state, next_state;
  logic [2:0]       flush_cnt;

  // Next-state logic: an exception in RUN starts a flush; the flush ends after FLUSH_CYCLES cycles.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (excp_valid) next_state = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // State register plus registered flush, flush-length counter and latched redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state     <= RUN;
      flush     <= 1'b0;
      flush_cnt <= '0;
      new_pc    <= '0;
    end else begin
      state     <= next_state;
      flush     <= (next_state == FLUSH);
      flush_cnt <= (state == FLUSH && next_state == FLUSH) ? flush_cnt + 1'b1 : 3'd0;
      if (state == RUN && excp_valid) new_pc <= excp_vector;
    end
  end

  // Stall merge: deepest request wins; nothing stalls during reset or a flush.
  always_comb begin
    stall = STALL_NONE;
    if (rst != RST_ENABLE && state == RUN) begin
      if (stallreq_mem)     stall = STALL_MEM;
      else if (stallreq_ex) stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
    end
  end

  // Saturating stalled-cycle counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (stall != STALL_NONE && stall_cycles != {CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

`ifdef PIPE_WATCHDOG_EN
  pipe_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .stall_pc (stall[0]),
    .in_flush (state == FLUSH),
    .timeout  (wdog_timeout)
  );
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expectations.
// A second instance with FLUSH_CYCLES=3 shares the inputs to check multi-cycle flushes.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_vector;
  logic        perf_clr;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles;
  logic        wdog_timeout;

  logic [5:0]  stall3;
  logic        flush3;
  logic [31:0] new_pc3;
  logic [3:0]  stall_cycles3;
  logic        wdog_timeout3;

  int tests_run = 0;
  int tests_failed = 0;

  pipeline_ctrl #(
    .FLUSH_CYCLES (1),
    .CNT_W        (4),
    .WDOG_LIMIT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_vector  (excp_vector),
    .perf_clr     (perf_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .wdog_timeout (wdog_timeout)
  );

  pipeline_ctrl #(
    .FLUSH_CYCLES (3),
    .CNT_W        (4),
    .WDOG_LIMIT   (8)
  ) dut3 (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_vector  (excp_vector),
    .perf_clr     (perf_clr),
    .stall        (stall3),
    .flush        (flush3),
    .new_pc       (new_pc3),
    .stall_cycles (stall_cycles3),
    .wdog_timeout (wdog_timeout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches.
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b1;
    excp_valid = 1'b0; excp_vector = 32'h0; perf_clr = 1'b0;

    // Reset state, with a request present to prove stall is masked in reset.
    step();
    check_output("rst_stall", 32'(stall), 32'h00);
    check_output("rst_flush", 32'(flush), 32'h0);
    check_output("rst_new_pc", new_pc, 32'h0);
    check_output("rst_cycles", 32'(stall_cycles), 32'h0);
    check_output("rst_wdog", 32'(wdog_timeout), 32'h0);
    stallreq_mem = 1'b0;
    step();
    rst = 1'b1;
    step();

    // ID hazard for three cycles.
    for (int i = 0; i < 3; i++) begin
      stallreq_id = 1'b1;
      #1 check_output("id_stall", 32'(stall), 32'h07);
      step();
    end
    stallreq_id = 1'b0;
    #1;
    check_output("id_cycles", 32'(stall_cycles), 32'h3);
    check_output("id_flush", 32'(flush), 32'h0);
    check_output("idle_stall", 32'(stall), 32'h00);

    // Deepest request wins; dropping mem falls back the same cycle.
    stallreq_id = 1'b1; stallreq_mem = 1'b1;
    #1 check_output("mem_id_stall", 32'(stall), 32'h1F);
    stallreq_mem = 1'b0;
    #1 check_output("drop_mem_stall", 32'(stall), 32'h07);
    stallreq_ex = 1'b1;
    #1 check_output("ex_id_stall", 32'(stall), 32'h0F);
    stallreq_ex = 1'b0;
    step();
    stallreq_id = 1'b0;
    #1 check_output("id_mem_cycles", 32'(stall_cycles), 32'h4);

    // Exception with a simultaneous EX stall, then an ignored exception during flush.
    excp_valid = 1'b1; excp_vector = 32'hBFC0_0380; stallreq_ex = 1'b1;
    #1;
    check_output("excp_stall", 32'(stall), 32'h0F);
    check_output("excp_no_comb_flush", 32'(flush), 32'h0);
    step();
    excp_vector = 32'h8000_0180;
    #1;
    check_output("flush_high", 32'(flush), 32'h1);
    check_output("flush_new_pc", new_pc, 32'hBFC0_0380);
    check_output("flush_stall", 32'(stall), 32'h00);
    check_output("flush3_high_1", 32'(flush3), 32'h1);
    step();
    excp_valid = 1'b0; stallreq_ex = 1'b0;
    #1;
    check_output("flush_low", 32'(flush), 32'h0);
    check_output("ignored_excp_new_pc", new_pc, 32'hBFC0_0380);
    check_output("flush_cycles", 32'(stall_cycles), 32'h5);
    check_output("flush3_high_2", 32'(flush3), 32'h1);
    check_output("flush3_new_pc", new_pc3, 32'hBFC0_0380);
    step();
    check_output("flush3_high_3", 32'(flush3), 32'h1);
    step();
    check_output("flush3_low", 32'(flush3), 32'h0);
    check_output("post_flush_low", 32'(flush), 32'h0);

`ifdef PIPE_WATCHDOG_EN
    // Seven stalled cycles stay under the limit; eight trip the sticky flag.
    stallreq_mem = 1'b1;
    repeat (7) step();
    stallreq_mem = 1'b0;
    #1 check_output("wdog_7_cycles", 32'(wdog_timeout), 32'h0);
    step();
    check_output("wdog_7_release", 32'(wdog_timeout), 32'h0);
    stallreq_mem = 1'b1;
    repeat (8) step();
    check_output("wdog_8_cycles", 32'(wdog_timeout), 32'h1);
    stallreq_mem = 1'b0;
    step();
    check_output("wdog_sticky", 32'(wdog_timeout), 32'h1);
`endif

    // Counter saturation and clear-beats-increment.
    stallreq_mem = 1'b1;
    repeat (20) step();
    check_output("sat_cycles", 32'(stall_cycles), 32'hF);
    check_output("sat_stall", 32'(stall), 32'h1F);
    perf_clr = 1'b1;
    step();
    check_output("clr_cycles", 32'(stall_cycles), 32'h0);
    perf_clr = 1'b0;
    step();
    check_output("count_after_clr", 32'(stall_cycles), 32'h1);
    stallreq_mem = 1'b0;
`ifndef PIPE_WATCHDOG_EN
    check_output("wdog_tied_low", 32'(wdog_timeout), 32'h0);
`endif

    // Reset asserted in the middle of a flush.
    excp_valid = 1'b1; excp_vector = 32'h1234_5678;
    step();
    excp_valid = 1'b0;
    #1;
    check_output("pre_rst_flush", 32'(flush), 32'h1);
    check_output("pre_rst_new_pc", new_pc, 32'h1234_5678);
    rst = 1'b0;
    #1;
    check_output("mid_rst_flush", 32'(flush), 32'h0);
    check_output("mid_rst_flush3", 32'(flush3), 32'h0);
    check_output("mid_rst_new_pc", new_pc, 32'h0);
    check_output("mid_rst_cycles", 32'(stall_cycles), 32'h0);
    check_output("mid_rst_wdog", 32'(wdog_timeout), 32'h0);
    step();
    rst = 1'b1;
    step();
    check_output("post_rst_flush", 32'(flush), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
